// File: rtl/load_store_unit.sv
// Data-memory access stage: turns ALU effective address plus control into a
// req/ack memory transaction, formats load results and flags faulty accesses.
module load_store_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] load_data,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [1:0]       code_q;
    logic [1:0]       code_next;
    logic             legal, misaligned, timeout_hit;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [31:0]      shifted, fmt_load;

    // Decode the incoming access: legality, alignment, lane enables and store data.
    always_comb begin
        legal      = 1'b0;
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (mem_read && !mem_write)
            legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (mem_write && !mem_read)
            legal = funct3 inside {3'b000, 3'b001, 3'b010};
        misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        case (funct3[1:0])
            2'b00:   be_next = 4'b0001 << addr[1:0];
            2'b01:   be_next = addr[1] ? 4'b1100 : 4'b0011;
            default: be_next = 4'b1111;
        endcase
        if (mem_write) begin
            case (funct3[1:0])
                2'b00:   wdata_next = {4{store_data[7:0]}};
                2'b01:   wdata_next = {2{store_data[15:0]}};
                default: wdata_next = store_data;
            endcase
        end
    end

    // The selected lane is shifted down to bit 0 before extension.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  fmt_load = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  fmt_load = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  fmt_load = {24'h0, shifted[7:0]};
            3'b101:  fmt_load = {16'h0, shifted[15:0]};
            default: fmt_load = shifted;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        code_next  = 2'b00;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!legal) begin
                        state_next = ERR;
                        code_next  = 2'b11;
                    end else if (misaligned) begin
                        state_next = ERR;
                        code_next  = 2'b01;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = ERR;
                    code_next  = 2'b10;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            code_q    <= 2'b00;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
            load_data <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= (state == REQ) ? cnt + 1'b1 : '0;
            if (state_next == ERR)
                code_q <= code_next;
            if (state == IDLE && state_next == REQ) begin
                funct3_q  <= funct3;
                off_q     <= addr[1:0];
                mem_we    <= mem_write;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wdata_next;
                mem_be    <= be_next;
            end
            if (state == REQ && mem_ack && !mem_we)
                load_data <= fmt_load;
        end
    end

    assign mem_req  = (state == REQ);
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign err_code = (state == ERR) ? code_q : 2'b00;
    assign stall    = (state == IDLE && req_valid) || (state == REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues the expected
// completion of each access and a negedge monitor checks every done/err pulse.
module tb_load_store_unit;

    localparam int TIMEOUT = 8;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] ld;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          nreq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] load_data;
    logic        done, err;
    logic [1:0]  err_code;
    logic        stall;

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .load_data(load_data),
        .done(done), .err(err), .err_code(err_code), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: tracks the request phase and checks each completion against the queue.
    int          req_cnt = 0;
    logic        unstable = 1'b0;
    logic [31:0] f_addr, f_wdata;
    logic        f_we;
    logic [3:0]  f_be;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_cnt  = 0;
            unstable = 1'b0;
        end else begin
            if (mem_req) begin
                if (req_cnt == 0) begin
                    f_addr = mem_addr; f_wdata = mem_wdata; f_we = mem_we; f_be = mem_be;
                end else if (mem_addr !== f_addr || mem_wdata !== f_wdata ||
                             mem_we !== f_we || mem_be !== f_be) begin
                    unstable = 1'b1;
                end
                req_cnt++;
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_response: got done=%0b err=%0b expected none",
                             done, err);
                end else begin
                    e = sb.pop_front();
                    checkOutput("err_vs_done", {31'h0, err}, {31'h0, e.is_err});
                    checkOutput("err_code", {30'h0, err_code}, e.is_err ? {30'h0, e.code} : 32'h0);
                    checkOutput("load_data", load_data, e.ld);
                    checkOutput("req_cycles", 32'(req_cnt), 32'(e.nreq));
                    if (e.nreq > 0) begin
                        checkOutput("mem_addr", f_addr, e.addr);
                        checkOutput("mem_we", {31'h0, f_we}, {31'h0, e.we});
                        checkOutput("mem_wdata", f_wdata, e.wdata);
                        checkOutput("mem_be", {28'h0, f_be}, {28'h0, e.be});
                        checkOutput("req_stable", {31'h0, unstable}, 32'h0);
                    end
                end
                req_cnt  = 0;
                unstable = 1'b0;
            end
        end
    end

    // waits = ack delay in REQ cycles; waits < 0 means the memory never acks.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd, input int waits,
                                 input logic [31:0] rdata, input exp_t ex);
        sb.push_back(ex);
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        checkOutput("stall_on_valid", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (ex.is_err && ex.code != 2'b10) begin
            @(negedge clk);
            checkOutput("err_pulse_timing", {31'h0, err}, 32'h1);
            checkOutput("stall_in_err", {31'h0, stall}, 32'h0);
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        checkOutput("stall_in_req", {31'h0, stall}, 32'h1);
        if (waits < 0) begin
            repeat (TIMEOUT) @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("timeout_err", {31'h0, err}, 32'h1);
            checkOutput("req_drop_after_timeout", {31'h0, mem_req}, 32'h0);
            @(posedge clk); #1;
            return;
        end
        repeat (waits) @(posedge clk);
        #1;
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        checkOutput("done_timing", {31'h0, done}, 32'h1);
        checkOutput("stall_in_done", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("reset_stall", {31'h0, stall}, 32'h0);
        checkOutput("reset_done_err", {30'h0, done, err}, 32'h0);
        checkOutput("reset_load_data", load_data, 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_mem_be", {28'h0, mem_be}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Loads
        applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF,
                      '{1'b0, 2'b00, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0, 4'b1111, 1});
        applyStimulus(1, 0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF1234,
                      '{1'b0, 2'b00, 32'hFFFFFF80, 32'h200, 1'b0, 32'h0, 4'b1000, 1});
        applyStimulus(1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF1234,
                      '{1'b0, 2'b00, 32'h00000080, 32'h200, 1'b0, 32'h0, 4'b1000, 1});
        applyStimulus(1, 0, 3'b101, 32'h202, 32'h0, 0, 32'h80FF1234,
                      '{1'b0, 2'b00, 32'h000080FF, 32'h200, 1'b0, 32'h0, 4'b1100, 1});
        applyStimulus(1, 0, 3'b001, 32'h202, 32'h0, 0, 32'h80FF1234,
                      '{1'b0, 2'b00, 32'hFFFF80FF, 32'h200, 1'b0, 32'h0, 4'b1100, 1});
        applyStimulus(1, 0, 3'b000, 32'h200, 32'h0, 2, 32'h80FF1234,
                      '{1'b0, 2'b00, 32'h00000034, 32'h200, 1'b0, 32'h0, 4'b0001, 3});
        // Stores leave load_data untouched
        applyStimulus(0, 1, 3'b001, 32'h12, 32'hAAAA5678, 5, 32'h0,
                      '{1'b0, 2'b00, 32'h00000034, 32'h10, 1'b1, 32'h56785678, 4'b1100, 6});
        applyStimulus(0, 1, 3'b000, 32'h21, 32'h123456AB, 0, 32'h0,
                      '{1'b0, 2'b00, 32'h00000034, 32'h20, 1'b1, 32'hABABABAB, 4'b0010, 1});
        applyStimulus(0, 1, 3'b010, 32'h30, 32'hCAFEF00D, 1, 32'h0,
                      '{1'b0, 2'b00, 32'h00000034, 32'h30, 1'b1, 32'hCAFEF00D, 4'b1111, 2});
        // Misaligned and illegal accesses
        applyStimulus(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0,
                      '{1'b1, 2'b01, 32'h00000034, 32'h0, 1'b0, 32'h0, 4'b0000, 0});
        applyStimulus(1, 0, 3'b001, 32'h103, 32'h0, 0, 32'h0,
                      '{1'b1, 2'b01, 32'h00000034, 32'h0, 1'b0, 32'h0, 4'b0000, 0});
        applyStimulus(0, 1, 3'b100, 32'h40, 32'h0, 0, 32'h0,
                      '{1'b1, 2'b11, 32'h00000034, 32'h0, 1'b0, 32'h0, 4'b0000, 0});
        applyStimulus(1, 1, 3'b010, 32'h40, 32'h0, 0, 32'h0,
                      '{1'b1, 2'b11, 32'h00000034, 32'h0, 1'b0, 32'h0, 4'b0000, 0});
        applyStimulus(0, 0, 3'b010, 32'h40, 32'h0, 0, 32'h0,
                      '{1'b1, 2'b11, 32'h00000034, 32'h0, 1'b0, 32'h0, 4'b0000, 0});
        applyStimulus(1, 0, 3'b011, 32'h41, 32'h0, 0, 32'h0,
                      '{1'b1, 2'b11, 32'h00000034, 32'h0, 1'b0, 32'h0, 4'b0000, 0});
        // Timeout, then an ack landing on the last allowed cycle
        applyStimulus(1, 0, 3'b010, 32'h40, 32'h0, -1, 32'h0,
                      '{1'b1, 2'b10, 32'h00000034, 32'h40, 1'b0, 32'h0, 4'b1111, TIMEOUT});
        applyStimulus(1, 0, 3'b010, 32'h44, 32'h0, TIMEOUT - 1, 32'h11223344,
                      '{1'b0, 2'b00, 32'h11223344, 32'h44, 1'b0, 32'h0, 4'b1111, TIMEOUT});
        applyStimulus(1, 0, 3'b101, 32'h46, 32'h0, 0, 32'h11223344,
                      '{1'b0, 2'b00, 32'h00001122, 32'h44, 1'b0, 32'h0, 4'b1100, 1});

        // Reset in the middle of a request; the late ack must be ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("midreset_stall", {31'h0, stall}, 32'h0);
        checkOutput("midreset_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        repeat (3) begin
            @(negedge clk);
            checkOutput("late_ack_no_req", {31'h0, mem_req}, 32'h0);
            checkOutput("late_ack_no_done", {31'h0, done}, 32'h0);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("late_ack_load_data", load_data, 32'h0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
